// File: rtl/traffic_pkg.sv
// Shared types for the highway/country traffic signal controller and its
// request front end: lamp encodings and the request FSM state.
package traffic_pkg;

  typedef enum logic [1:0] {
    LAMP_GREEN  = 2'b00,
    LAMP_RED    = 2'b01,
    LAMP_YELLOW = 2'b10
  } lamp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVE,
    ST_LOCKOUT
  } req_state_e;

  localparam int               QUEUE_W   = 4;
  localparam logic [QUEUE_W-1:0] QUEUE_MAX = 4'd15;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus counting debouncer for the country loop sensor.
// det_rise/det_fall flag the edge at which det is about to change.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_raw,
  output logic det,
  output logic det_rise,
  output logic det_fall
);

  localparam int             CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             det_q, det_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    s1_d     = sensor_raw;
    s2_d     = s1_q;
    det_d    = det_q;
    db_cnt_d = '0;
    // The count holds stable-but-different samples; the last one flips det.
    if (s2_q != det_q) begin
      if (db_cnt_q == CNT_LAST) begin
        det_d = s2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      det_q    <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      det_q    <= det_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign det      = det_q;
  assign det_rise = det_d & ~det_q;
  assign det_fall = ~det_d & det_q;

endmodule

// File: rtl/vehicle_request_detector.sv
// Turns the country loop sensor into the controller request x: queue counting,
// request FSM with a hold limit on country green and a highway lockout.
module vehicle_request_detector
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_HOLD        = 16,
  parameter int HWY_MIN         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sensor_raw,
  input  logic               cntry_green,
  output logic               x,
  output logic [QUEUE_W-1:0] queue_cnt,
  output logic               overflow
);

  localparam int              HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int              LOCK_W    = (HWY_MIN > 1) ? $clog2(HWY_MIN) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(HWY_MIN - 1);

  logic det, det_rise, det_fall;
  logic arrival, departure;

  req_state_e         state_q, state_d;
  logic [QUEUE_W-1:0] queue_q, queue_d;
  logic               overflow_q, overflow_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic               x_q, x_d;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .sensor_raw(sensor_raw),
    .det       (det),
    .det_rise  (det_rise),
    .det_fall  (det_fall)
  );

  // A vehicle entering while country is red joins the queue; one leaving
  // while country is green has been served.
  assign arrival   = det_rise & ~cntry_green;
  assign departure = det_fall & cntry_green;

  always_comb begin
    queue_d    = queue_q;
    overflow_d = overflow_q;
    if (arrival) begin
      if (queue_q == QUEUE_MAX) overflow_d = 1'b1;
      else                      queue_d    = queue_q + 1'b1;
    end else if (departure && queue_q != '0) begin
      queue_d = queue_q - 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      ST_IDLE: if (queue_q != '0 || det) state_d = ST_REQ;
      ST_REQ: begin
        if (cntry_green) begin
          state_d    = ST_SERVE;
          hold_cnt_d = '0;
        end
      end
      ST_SERVE: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (!cntry_green) begin
          state_d = ST_IDLE;
        end else if (queue_q == '0 && !det) begin
          state_d = ST_IDLE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_LOCKOUT;
          lock_cnt_d = '0;
        end
      end
      ST_LOCKOUT: begin
        // The highway minimum only runs once country green has actually dropped.
        if (!cntry_green) begin
          if (lock_cnt_q == LOCK_LAST) state_d    = ST_IDLE;
          else                         lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    x_d = (state_d == ST_REQ) || (state_d == ST_SERVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      queue_q    <= '0;
      overflow_q <= 1'b0;
      hold_cnt_q <= '0;
      lock_cnt_q <= '0;
      x_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      queue_q    <= queue_d;
      overflow_q <= overflow_d;
      hold_cnt_q <= hold_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      x_q        <= x_d;
    end
  end

  assign x         = x_q;
  assign queue_cnt = queue_q;
  assign overflow  = overflow_q;

endmodule
